// File: rtl/layer_result_collector_if.sv
// layer_result_collector_if: neuron start/done, result bus and output stream bundle
interface layer_result_collector_if #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
);
  logic                          layer_start;
  logic                          busy;
  logic                          neuron_start;
  logic [NUM_NEURONS-1:0]        neuron_done;
  logic [NUM_NEURONS*DATA_W-1:0] neuron_result;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_W-1:0]             out_data;
  logic [IDX_W-1:0]              out_index;
  logic                          out_last;
  logic [IDX_W-1:0]              argmax_idx;
  logic                          layer_done;
  logic                          err_timeout;
  modport master (
    output layer_start, neuron_done, neuron_result, out_ready,
    input  busy, neuron_start, out_valid, out_data, out_index, out_last, argmax_idx, layer_done, err_timeout
  );
  modport slave (
    input  layer_start, neuron_done, neuron_result, out_ready,
    output busy, neuron_start, out_valid, out_data, out_index, out_last, argmax_idx, layer_done, err_timeout
  );
endinterface

// File: rtl/layer_result_collector.sv
// layer_result_collector: launches a layer, captures neuron results, streams them out with argmax
module layer_result_collector #(
  parameter int NUM_NEURONS    = 10,
  parameter int DATA_W         = 16,
  parameter int APPLY_RELU     = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDX_W          = $clog2(NUM_NEURONS)
) (
  input logic clk,
  input logic rst,
  layer_result_collector_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} state_t;
  state_t state, state_n;
  logic [NUM_NEURONS-1:0] mask, cap, mask_n;
  logic signed [DATA_W-1:0] rbuf [NUM_NEURONS];
  logic signed [DATA_W-1:0] buf_n [NUM_NEURONS];
  logic signed [DATA_W-1:0] mx;
  logic [IDX_W-1:0] cnt, am, am_q;
  logic [TW-1:0] tcnt;
  logic full_n, tout, acc, last, done_q, err_q;
  // buf_n folds this cycle's captures in so argmax is ready on the WAIT->DRAIN edge
  always_comb begin
    cap = (state == WAIT) ? bus.neuron_done & ~mask : '0;
    mask_n = mask | cap;
    full_n = &mask_n;
    tout = (state == WAIT) && !full_n && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    acc = bus.out_valid && bus.out_ready;
    last = cnt == IDX_W'(NUM_NEURONS - 1);
    for (int i = 0; i < NUM_NEURONS; i++)
      buf_n[i] = !cap[i] ? rbuf[i] :
                 (APPLY_RELU != 0 && bus.neuron_result[i*DATA_W+DATA_W-1]) ? '0 :
                 bus.neuron_result[i*DATA_W +: DATA_W];
    am = '0;
    mx = buf_n[0];
    for (int i = 1; i < NUM_NEURONS; i++)
      if (buf_n[i] > mx) begin
        mx = buf_n[i];
        am = IDX_W'(i);
      end
    state_n = state;
    case (state)
      IDLE:    state_n = bus.layer_start ? START : IDLE;
      START:   state_n = WAIT;
      WAIT:    state_n = full_n ? DRAIN : tout ? IDLE : WAIT;
      default: state_n = (acc && last) ? IDLE : DRAIN;
    endcase
  end
  assign bus.busy         = state != IDLE;
  assign bus.neuron_start = state == START;
  assign bus.out_valid    = state == DRAIN;
  assign bus.out_index    = cnt;
  assign bus.out_data     = bus.out_valid ? rbuf[cnt] : '0;
  assign bus.out_last     = bus.out_valid && last;
  assign bus.argmax_idx   = am_q;
  assign bus.layer_done   = done_q;
  assign bus.err_timeout  = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mask   <= '0;
      cnt    <= '0;
      tcnt   <= '0;
      am_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      mask   <= (state == IDLE) ? '0 : mask_n;
      tcnt   <= (state == IDLE) ? '0 : (state == WAIT) ? tcnt + 1'b1 : tcnt;
      cnt    <= acc ? (last ? '0 : cnt + 1'b1) : cnt;
      am_q   <= (state == WAIT && full_n) ? am : am_q;
      done_q <= acc && last;
      err_q  <= tout;
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_NEURONS; i++) rbuf[i] <= buf_n[i];
endmodule

// File: tb/tb_layer_result_collector.sv
// tb_layer_result_collector: directed scenarios with a beat scoreboard on a ReLU and a pass-through instance
module tb_layer_result_collector;
  logic clk = 0, rst = 1, sel = 0;
  logic layer_start = 0, out_ready = 0;
  logic [3:0] neuron_done = '0;
  logic [63:0] neuron_result = '0;
  int checks = 0, errors = 0;
  typedef struct packed {logic [15:0] d; logic [1:0] i; logic l;} beat_t;
  beat_t exp_q[$];
  always #5 clk = ~clk;
  layer_result_collector_if #(.NUM_NEURONS(4), .DATA_W(16)) ia();
  layer_result_collector_if #(.NUM_NEURONS(4), .DATA_W(16)) ib();
  layer_result_collector #(.NUM_NEURONS(4), .DATA_W(16), .APPLY_RELU(1), .TIMEOUT_CYCLES(8))
    dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  layer_result_collector #(.NUM_NEURONS(4), .DATA_W(16), .APPLY_RELU(0), .TIMEOUT_CYCLES(8))
    dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  assign ia.layer_start = layer_start;
  assign ib.layer_start = layer_start;
  assign ia.neuron_done = neuron_done;
  assign ib.neuron_done = neuron_done;
  assign ia.neuron_result = neuron_result;
  assign ib.neuron_result = neuron_result;
  assign ia.out_ready = out_ready;
  assign ib.out_ready = out_ready;
  wire o_busy   = sel ? ib.busy : ia.busy;
  wire o_nstart = sel ? ib.neuron_start : ia.neuron_start;
  wire o_valid  = sel ? ib.out_valid : ia.out_valid;
  wire [15:0] o_data = sel ? ib.out_data : ia.out_data;
  wire [1:0] o_index = sel ? ib.out_index : ia.out_index;
  wire o_last   = sel ? ib.out_last : ia.out_last;
  wire [1:0] o_am = sel ? ib.argmax_idx : ia.argmax_idx;
  wire o_done   = sel ? ib.layer_done : ia.layer_done;
  wire o_err    = sel ? ib.err_timeout : ia.err_timeout;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic set_res(input logic [15:0] r0, r1, r2, r3);
    neuron_result = {r3, r2, r1, r0};
  endtask
  task automatic push4(input logic [15:0] d0, d1, d2, d3);
    exp_q.push_back({d0, 2'd0, 1'b0});
    exp_q.push_back({d1, 2'd1, 1'b0});
    exp_q.push_back({d2, 2'd2, 1'b0});
    exp_q.push_back({d3, 2'd3, 1'b1});
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_nstart"}, o_nstart, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_index"}, o_index, 0);
    chk({tag, "_last"}, o_last, 0);
    chk({tag, "_argmax"}, o_am, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask
  // called at a negedge in IDLE; returns at the negedge of the first WAIT cycle
  task automatic launch();
    layer_start = 1;
    step();
    layer_start = 0;
    chk("neuron_start", o_nstart, 1);
    chk("busy_start", o_busy, 1);
    step();
    chk("neuron_start_once", o_nstart, 0);
    chk("busy_wait", o_busy, 1);
  endtask
  task automatic drain(input logic [15:0] pat, input logic [1:0] exp_am);
    logic prev_acc = 0;
    bit seen = 0;
    int c = 0;
    beat_t b;
    while (!seen && c < 40) begin
      out_ready = pat[c % 16];
      chk("out_valid", o_valid, exp_q.size() != 0);
      chk("layer_done_timing", o_done, prev_acc);
      if (o_valid) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        chk("argmax_drain", o_am, exp_am);
        if (exp_q.size() != 0) begin
          b = exp_q[0];
          chk("out_data", o_data, b.d);
          chk("out_index", o_index, b.i);
          chk("out_last", o_last, b.l);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_acc = o_valid && out_ready && o_last;
      seen = o_done;
      c++;
      step();
    end
    chk("layer_done_seen", seen, 1);
    out_ready = 0;
    chk("busy_after_done", o_busy, 0);
    exp_q.delete();
  endtask
  initial begin
    int k;
    step();
    step();
    check_idle_outputs("reset");
    rst = 0;
    step();
    // ReLU layer, all results one cycle after start
    launch();
    set_res(16'd5, 16'hFFFD, 16'h7FFF, 16'd2);
    neuron_done = 4'hF;
    push4(16'd5, 16'd0, 16'h7FFF, 16'd2);
    step();
    neuron_done = 0;
    chk("t1_first_valid", o_valid, 1);
    drain(16'hFFFF, 2'd2);
    // pass-through layer with a tie for the maximum
    sel = 1;
    launch();
    set_res(16'hFFF9, 16'hFFFE, 16'hFFFE, 16'hFFF7);
    neuron_done = 4'hF;
    push4(16'hFFF9, 16'hFFFE, 16'hFFFE, 16'hFFF7);
    step();
    neuron_done = 0;
    drain(16'hFFFF, 2'd1);
    // staggered completion with a repeat done on neuron 0
    sel = 0;
    launch();
    push4(16'd40, 16'd22, 16'd0, 16'd11);
    for (int s = 1; s <= 7; s++) begin
      neuron_done = 4'h0;
      if (s == 1) begin neuron_done = 4'b1000; set_res(16'd0, 16'd0, 16'd0, 16'd11); end
      if (s == 2) begin neuron_done = 4'b0010; set_res(16'd0, 16'd22, 16'd0, 16'd0); end
      if (s == 5) begin neuron_done = 4'b0001; set_res(16'd40, 16'd0, 16'd0, 16'd0); end
      if (s == 6) begin neuron_done = 4'b0001; set_res(16'd99, 16'd0, 16'd0, 16'd0); end
      if (s == 7) begin neuron_done = 4'b0100; set_res(16'd0, 16'd0, 16'hFFFB, 16'd0); end
      step();
      chk("t3_valid_gate", o_valid, s == 7);
    end
    neuron_done = 0;
    drain(16'hFFFF, 2'd0);
    // back-pressure with ready pattern 1,0,0,1,0,0,...
    launch();
    set_res(16'd100, 16'hFFFF, 16'd300, 16'd7);
    neuron_done = 4'hF;
    push4(16'd100, 16'd0, 16'd300, 16'd7);
    step();
    neuron_done = 0;
    drain(16'b1001001001001001, 2'd2);
    // timeout with neuron 2 never reporting
    launch();
    set_res(16'd1, 16'd2, 16'd3, 16'd4);
    neuron_done = 4'b1011;
    step();
    neuron_done = 0;
    k = 1;
    while (!o_err && k < 20) begin
      chk("t5_no_valid", o_valid, 0);
      step();
      k++;
    end
    chk("t5_timeout_cycles", k, 8);
    chk("t5_busy", o_busy, 0);
    chk("t5_valid", o_valid, 0);
    step();
    chk("t5_err_pulse", o_err, 0);
    // reset in the middle of DRAIN
    launch();
    set_res(16'd10, 16'd20, 16'd30, 16'd40);
    neuron_done = 4'hF;
    step();
    neuron_done = 0;
    out_ready = 1;
    step();
    out_ready = 0;
    chk("t6_index_before_rst", o_index, 1);
    chk("t6_argmax_before_rst", o_am, 3);
    rst = 1;
    step();
    rst = 0;
    check_idle_outputs("t6_rst");
    step();
    launch();
    layer_start = 1;
    step();
    chk("t6_busy_start_ignored", o_nstart, 0);
    step();
    chk("t6_busy_start_ignored2", o_nstart, 0);
    layer_start = 0;
    set_res(16'd5, 16'd6, 16'd7, 16'd8);
    neuron_done = 4'hF;
    push4(16'd5, 16'd6, 16'd7, 16'd8);
    step();
    neuron_done = 0;
    drain(16'hFFFF, 2'd3);
    chk("t6_no_restart", o_nstart, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
